sha256_compress: RTL

//  Iterative SHA-256 compression engine: one 512-bit padded block in, one round per clock, 256-bit digest out.

---
 rtl/sha256_pkg.sv | 47 ++++
 rtl/sha256_msg_sched.sv | 37 +++
 rtl/sha256_compress.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: FSM state encoding, initial hash value and
// the round/schedule mixing functions used by the compression engine.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_ADD,
        ST_DONE
    } state_t;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16-word sliding window over W_t, loaded with the
// block and advanced one word per round. o_w is W_t for the current round.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [511:0] i_block,
    output logic [31:0]  o_w
);

    // Window word j (W_{t+j}) lives at win[15-j], so the block loads directly
    // with W0 in the top word and each shift moves words towards the top.
    logic [15:0][31:0] win;
    logic [31:0]       w_new;

    assign o_w = win[15];

    // Next schedule word from W_{t+14}, W_{t+9}, W_{t+1}, W_t
    always_comb begin
        w_new = small_s1(win[1]) + win[6] + small_s0(win[14]) + win[15];
    end

    // Window register: load on accept, shift once per round
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            win <= '0;
        end else if (i_load) begin
            win <= i_block;
        end else if (i_shift) begin
            win <= {win[14:0], w_new};
        end
    end

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression engine, one round per clock. The K constant
// for round o_coef_num comes back combinationally on i_coef_value.
// Optional feature macro: SHA256_CHAIN_EN (internal chaining with IV select
// via i_first instead of an external i_hash_in).
module sha256_compress
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [511:0]     i_block,
`ifdef SHA256_CHAIN_EN
    input  logic             i_first,
`else
    input  logic [255:0]     i_hash_in,
`endif
    output logic [CNT_W-1:0] o_coef_num,
    input  logic [31:0]      i_coef_value,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [255:0]     o_digest
);

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

    // Index 7 is a / H0 so the packed arrays line up with the 256-bit buses.
    state_t            state;
    logic [7:0][31:0]  work;
    logic [7:0][31:0]  hv;
    logic [7:0][31:0]  sum;
    logic [255:0]      chain;
    logic [31:0]       w_t;
    logic [31:0]       t1;
    logic [31:0]       t2;
    logic              accept;

    assign accept = o_ready && i_valid;

    sha256_msg_sched u_msg_sched (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (accept),
        .i_shift (state == ST_ROUND),
        .i_block (i_block),
        .o_w     (w_t)
    );

    // Chaining input selection
    always_comb begin
`ifdef SHA256_CHAIN_EN
        chain = i_first ? SHA256_IV : o_digest;
`else
        chain = i_hash_in;
`endif
    end

    // Round temporaries and final per-word additions
    always_comb begin
        t1 = work[0] + big_s1(work[3]) + ch(work[3], work[2], work[1]) + i_coef_value + w_t;
        t2 = big_s0(work[7]) + maj(work[7], work[6], work[5]);
        for (int unsigned i = 0; i < 8; i++) begin
            sum[i] = hv[i] + work[i];
        end
    end

    // Control FSM with registered handshake, round index and digest
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_coef_num <= '0;
            o_digest   <= '0;
            work       <= '0;
            hv         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_ROUND;
                        o_ready    <= 1'b0;
                        o_coef_num <= '0;
                        work       <= chain;
                        hv         <= chain;
                    end
                end
                ST_ROUND: begin
                    work[7] <= t1 + t2;
                    work[6] <= work[7];
                    work[5] <= work[6];
                    work[4] <= work[5];
                    work[3] <= work[4] + t1;
                    work[2] <= work[3];
                    work[1] <= work[2];
                    work[0] <= work[1];
                    if (o_coef_num == LAST_ROUND) begin
                        state      <= ST_ADD;
                        o_coef_num <= '0;
                    end else begin
                        o_coef_num <= o_coef_num + CNT_W'(1);
                    end
                end
                ST_ADD: begin
                    hv       <= sum;
                    o_digest <= sum;
                    o_valid  <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
